// File: rtl/sram_line_scheduler.sv
// sram_line_scheduler: sequences write/read addresses and bank-rotation
// strobes for the three-bank line SRAM interface (CNN and FC jobs).
module sram_line_scheduler #(
  parameter int AW = 10,
  parameter int LW = 8
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          start_i,
  input  logic [3:0]    mode_i,
  input  logic [AW-1:0] line_words_i,
  input  logic [LW-1:0] pic_lines_i,
  input  logic          in_vld_i,
  output logic          in_rdy_o,
  input  logic          rd_en_i,
  output logic          wdata_vld_o,
  output logic [AW+1:0] waddr_o,
  output logic [AW+1:0] raddr_o,
  output logic          raddr_vld_o,
  output logic          data_sop_o,
  output logic          data_eop_o,
  output logic          wsram_2line_o,
  output logic          r2wrsram_o,
  output logic          wrsram_bank_change_o,
  output logic          wr2rsram_o,
  output logic          r2bank_done_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_FILL, S_WR, S_DRAIN, S_FC_W, S_FC_R} state_t;

  state_t        state_q, next_q;
  logic [1:0]    wbank_q, rbank_q;
  logic [AW-1:0] wcnt_q, rcnt_q, lw_q;
  logic [LW-1:0] lines_q, pl_q;
  logic          fc_q, wdone_q, rdone_q, rhalf_q, busy_q, err_q, eop_q;
  logic          sop_q, two_q, r2w_q, bc_q, w2r_q, done_q;

  logic          rd_ok, w_beat, r_beat, w_last_cnt, r_last_cnt, w_last;
  logic          r_fin_now, w_fin, r_fin, reject;
  logic [AW-1:0] lw_m1;
  logic [LW-1:0] lines_inc, lines_now;

  function automatic logic [1:0] inc3(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  // Access enables and end-of-line / end-of-phase detection
  assign lw_m1       = lw_q - AW'(1);
  assign in_rdy_o    = (state_q == S_FILL) || (state_q == S_FC_W) || ((state_q == S_WR) && !wdone_q);
  assign rd_ok       = ((state_q == S_WR) || (state_q == S_DRAIN) || (state_q == S_FC_R)) && !rdone_q;
  assign wdata_vld_o = in_vld_i & in_rdy_o;
  assign raddr_vld_o = rd_en_i & rd_ok;
  assign w_beat      = wdata_vld_o;
  assign r_beat      = raddr_vld_o;
  assign w_last_cnt  = (wcnt_q == lw_m1);
  assign r_last_cnt  = (rcnt_q == lw_m1);
  assign w_last      = w_beat & w_last_cnt;
  // FC reads a single line; CNN reads two lines per phase
  assign r_fin_now   = r_beat & r_last_cnt & (rhalf_q | fc_q);
  assign w_fin       = wdone_q | w_last;
  assign r_fin       = rdone_q | r_fin_now;
  assign lines_inc   = lines_q + LW'(1);
  assign lines_now   = w_last ? lines_inc : lines_q;
  assign reject      = (mode_i == 4'd0) || (line_words_i == '0) ||
                       (!mode_i[3] && (pic_lines_i < LW'(3)));

  assign waddr_o              = {wbank_q, wcnt_q};
  assign raddr_o              = {rbank_q, rcnt_q};
  assign data_sop_o           = sop_q;
  assign data_eop_o           = eop_q;
  assign wsram_2line_o        = two_q;
  assign r2wrsram_o           = r2w_q;
  assign wrsram_bank_change_o = bc_q;
  assign wr2rsram_o           = w2r_q;
  assign r2bank_done_o        = done_q;
  assign busy_o               = busy_q;
  assign err_o                = err_q;

  // Phase FSM, counters and single-cycle strobes
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q <= S_IDLE;  next_q  <= S_IDLE;
      wbank_q <= '0;      rbank_q <= '0;
      wcnt_q  <= '0;      rcnt_q  <= '0;   lw_q <= '0;
      lines_q <= '0;      pl_q    <= '0;
      fc_q    <= 1'b0;    wdone_q <= 1'b0; rdone_q <= 1'b0; rhalf_q <= 1'b0;
      busy_q  <= 1'b0;    err_q   <= 1'b0; eop_q   <= 1'b0;
      sop_q   <= 1'b0;    two_q   <= 1'b0; r2w_q   <= 1'b0;
      bc_q    <= 1'b0;    w2r_q   <= 1'b0; done_q  <= 1'b0;
    end else begin
      err_q <= 1'b0; eop_q <= 1'b0; sop_q <= 1'b0; two_q <= 1'b0;
      r2w_q <= 1'b0; bc_q  <= 1'b0; w2r_q <= 1'b0; done_q <= 1'b0;

      // Write word counter; the final line of the job raises data_eop
      if (w_beat) begin
        if (w_last_cnt) begin
          wcnt_q  <= '0;
          lines_q <= lines_inc;
          wdone_q <= 1'b1;
          if (fc_q || (lines_inc == pl_q)) eop_q <= 1'b1;
        end else begin
          wcnt_q <= wcnt_q + AW'(1);
        end
      end

      // Read word counter; first line end moves to the second read bank
      if (r_beat) begin
        if (r_last_cnt) begin
          rcnt_q <= '0;
          if (rhalf_q || fc_q) rdone_q <= 1'b1;
          else begin
            rhalf_q <= 1'b1;
            rbank_q <= inc3(rbank_q);
          end
        end else begin
          rcnt_q <= rcnt_q + AW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (reject) err_q <= 1'b1;
            else begin
              state_q <= S_GAP;
              next_q  <= mode_i[3] ? S_FC_W : S_FILL;
              fc_q    <= mode_i[3];
              lw_q    <= line_words_i;
              pl_q    <= pic_lines_i;
              wbank_q <= '0; rbank_q <= '0;
              wcnt_q  <= '0; rcnt_q  <= '0; lines_q <= '0;
              busy_q  <= 1'b1;
              sop_q   <= 1'b1;
            end
          end
        end
        S_GAP: begin
          // Each phase starts with fresh completion flags and the first read bank
          state_q <= next_q;
          wdone_q <= 1'b0;
          rdone_q <= 1'b0;
          rhalf_q <= 1'b0;
          rbank_q <= fc_q ? 2'd0 : inc3(wbank_q);
          if (next_q == S_IDLE) busy_q <= 1'b0;
        end
        S_FILL: begin
          if (w_last) begin
            state_q <= S_GAP;
            if (lines_q == '0) begin
              wbank_q <= 2'd1; two_q <= 1'b1; next_q <= S_FILL;
            end else begin
              wbank_q <= 2'd2; r2w_q <= 1'b1; next_q <= S_WR;
            end
          end
        end
        S_WR: begin
          if (w_fin && r_fin) begin
            state_q <= S_GAP;
            wbank_q <= inc3(wbank_q);
            bc_q    <= 1'b1;
            if (lines_now == pl_q) begin
              w2r_q  <= 1'b1;
              next_q <= S_DRAIN;
            end else begin
              next_q <= S_WR;
            end
          end
        end
        S_DRAIN, S_FC_R: begin
          if (r_fin_now) begin
            state_q <= S_GAP; done_q <= 1'b1; next_q <= S_IDLE;
          end
        end
        S_FC_W: begin
          if (w_last) begin
            state_q <= S_GAP; next_q <= S_FC_R;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_line_scheduler.md
# sram_line_scheduler

Sequencing controller for the three-bank line SRAM interface (`gen_sram_interface`). It accepts a start command, then produces every control strobe and address that interface consumes:

- write addresses for the upstream pixel stream;
- read addresses for the downstream window reader;
- the bank-rotation strobes (`data_sop`, `wsram_2line`, `r2wrsram`, `wrsram_bank_change`, `wr2rsram`, `r2bank_done`, `DATA_EOP`).

It sits between the layer controller/DMA and the SRAM interface, with write data passing alongside it.

## Interface
- `AW`, 10, word-address width inside one bank; bank address is `{bank[1:0], word[AW-1:0]}`
- `LW`, 8, line-count width
- `SYS_CLK`  in  1  single clock
- `SYS_RST`  in  1  asynchronous, active-low reset
- `start_i`  in  1  job start pulse; ignored unless `busy_o`=0
- `mode_i`  in  4  sampled at accepted start; `mode_i[3]`=1 selects FC, else `mode_i[2:0]`≠0 selects CNN
- `line_words_i`  in  AW  words per line (1..2^AW-1), sampled at start
- `pic_lines_i`  in  LW  lines per picture (CNN: ≥3), sampled at start
- `in_vld_i`  in  1  upstream write word valid
- `in_rdy_o`  out  1  scheduler accepts a write word
- `rd_en_i`  in  1  downstream ready for a read beat
- `wdata_vld_o`  out  1  `in_vld_i & in_rdy_o`, combinational
- `waddr_o`  out  AW+2  write address, registered
- `raddr_o`  out  AW+2  read address, registered
- `raddr_vld_o`  out  1  `rd_en_i & rd_ok`, combinational
- `data_sop_o`, `data_eop_o`, `wsram_2line_o`, `r2wrsram_o`, `wrsram_bank_change_o`, `wr2rsram_o`, `r2bank_done_o`  out  1 each  registered single-cycle strobes
- `busy_o`  out  1  job in progress
- `err_o`  out  1  one-cycle pulse when a start is rejected

## Operation
- **States:** IDLE, GAP, FILL, WR, DRAIN, FC_W, FC_R.
- **GAP:** one cycle in which exactly the pending strobe(s) are high and `in_rdy_o`/`rd_ok` are 0. The following state begins on the next cycle, so the interface's CEN/WEN update lands before any access.
- **IDLE:**
  - On `start_i`, reject the job with `err_o` if `mode_i`=0, `line_words_i`=0, or (CNN and `pic_lines_i`<3).
  - Otherwise clear `wbank`, `wcnt`, `rcnt` and `lines`, raise `busy_o`, and enter GAP with `data_sop_o`. The next state is FILL (CNN) or FC_W (FC).
- **Write beat:** `waddr_o` = `{wbank, wcnt}`. Each accepted beat increments `wcnt`. The last beat of a line (`wcnt`=`line_words`-1) clears `wcnt`, increments `lines`, and blocks further writes.
- **FILL (CNN):**
  - After line 0: `wbank`←1, GAP with `wsram_2line_o`, back to FILL.
  - After line 1: `wbank`←2, GAP with `r2wrsram_o`, enter WR.
- **WR:** writes one line to `wbank` while reading 2×`line_words` beats.
  - Read order: bank (`wbank`+1)%3 words 0..N-1, then bank (`wbank`+2)%3 words 0..N-1.
  - Write and read progress independently; the side that finishes first stalls.
  - When both finish, `wbank`←(`wbank`+1)%3 and the FSM enters GAP with `wrsram_bank_change_o`.
  - If `lines`==`pic_lines`, `wr2rsram_o` is also high in that GAP and the next state is DRAIN; otherwise the next state is WR.
- **DRAIN:** 2N reads in the same order (the last two lines written), then GAP with `r2bank_done_o`, then IDLE with `busy_o`←0.
- **FC_W:** writes `line_words` beats to bank 0, then GAP with no strobe except `data_eop_o`, which has already fired. Next state is FC_R.
- **FC_R:** reads bank 0 words 0..N-1, then GAP with `r2bank_done_o`, then IDLE.
- **`data_eop_o`:** pulses the cycle after the last write beat of the job, in both modes.
- **Arithmetic:** the bank index wraps modulo 3, never reaching 3. `wcnt`/`rcnt` compare against `line_words`-1; `lines` compares against the sampled `pic_lines`.
- **Boundaries:**
  - `start_i` while busy: ignored, no `err_o`.
  - `mode_i` and the sizes changing mid-job: no effect.
  - Reset mid-job: the FSM returns to IDLE immediately and all outputs drop to reset values.

## Timing
- **Reset values:** all outputs 0; `waddr_o`=0, `raddr_o`=0.
- **Start accepted at cycle T:** `busy_o`=1 and `data_sop_o`=1 at T+1; `in_rdy_o`=1 from T+2.
- **Write throughput:** one beat per cycle while `in_vld_i`=1.
- **Read throughput:** one beat per cycle while `rd_en_i`=1. `raddr_o` is valid in the same cycle as `raddr_vld_o`, and the interface returns data one cycle later.
- **Last beat of a phase at cycle t:** strobe(s) at t+1 (GAP); accesses resume at t+2. The inter-phase gap is always exactly one cycle after the slower side completes.
- **`r2bank_done_o`:** one cycle after the final read beat; `busy_o` falls the following cycle.

## Test plan
1. **CNN job, `line_words`=4, `pic_lines`=4, `in_vld_i`=`rd_en_i`=1:**
   - strobe order `data_sop`, `wsram_2line`, `r2wrsram`, `bank_change`, `bank_change`+`wr2rsram`, `r2bank_done`;
   - 16 write beats to banks 0,1,2,0;
   - 24 read beats in bank order 0,1 | 1,2 | 2,0, words 0..3 each.
2. **FC job, `line_words`=3:** writes to 0x000..0x002; `data_eop_o` one cycle after the third write; reads 0x000..0x002; `r2bank_done_o` one cycle after the last read.
3. **Backpressure in WR:** hold `rd_en_i`=0 for 10 cycles while writes complete. Required: writes stall after the line ends, `bank_change` appears only one cycle after the last read, and no address is skipped or repeated.
4. **Rejected starts:** start with `pic_lines_i`=2 (CNN), then `line_words_i`=0, then `mode_i`=0. Each gives `err_o`=1 for one cycle, `busy_o` stays 0, and no strobes are issued.
5. **Start while busy, then mode change mid-job:** both ignored; the job completes with its original parameters.
6. **Reset asserted mid-WR:** all outputs are 0 asynchronously. A new start after release runs a clean CNN job from bank 0.
